regfile_lvt_multiport: RTL and testbench
========================================

Name: regfile_lvt_multiport

Overview:
- Parametrised multi-port register file built on a live-value table (LVT); the successor to the two-write-port bank-select table.
- Each write port owns NUM_READ replicated flop banks. The LVT records, per register, which write port holds the live copy. Each read port muxes its replicas by the LVT entry.
- Sits in the cpu32e2 regfile between writeback (multiple retire lanes) and operand fetch.

Parameters:
- NUM_WRITE, 2, number of write ports (1..4)
- NUM_READ, 2, number of read ports (1..6)
- DEPTH, 32, number of registers (power of two, at least 2)
- WIDTH, 32, data bits per register
- ZERO_REG, 1, when 1 register 0 reads as zero and ignores writes

Ports:
- clk  input  1  clock, rising edge
- resetN  input  1  asynchronous active-low reset
- writeEnable  input  [NUM_WRITE]  per-port write strobe
- writeAddress  input  [NUM_WRITE][ADDR_W]  per-port write index; ADDR_W = $clog2(DEPTH)
- writeData  input  [NUM_WRITE][WIDTH]  per-port write data
- readAddress  input  [NUM_READ][ADDR_W]  per-port read index
- readData  output  [NUM_READ][WIDTH]  per-port read data, combinational
- writeConflict  output  1  registered; 1 for one cycle after a same-address multi-port write

Behaviour:
- Reset (resetN low, asynchronous):
  - all LVT entries = 0; all bank flops = 0; writeConflict = 0.
  - Every readData reads 0 in the first cycle after reset.
- Write, per port p with writeEnable[p]=1:
  - at the clk edge, write writeData[p] to writeAddress[p] in all NUM_READ replicas of bank p.
  - Set LVT[writeAddress[p]] = p.
- Simultaneous same-address writes: the lowest-index enabled port wins.
  - Only the winner updates the LVT and its banks.
  - Losing ports' banks are left unchanged (suppressed write).
  - writeConflict = 1 on the next cycle; otherwise 0.
- Different addresses written in the same cycle: all ports commit independently.
- ZERO_REG=1:
  - writes to address 0 are dropped: no bank or LVT update, and no contribution to writeConflict.
  - readData for address 0 is forced to 0.
- Read, per port r:
  - readData[r] = bank[LVT[readAddress[r]]][r][readAddress[r]], combinational, zero latency.
  - Read-during-write to the same address returns the old value; the new value is visible the cycle after the edge.
- LVT entry width is PORT_W = max(1, $clog2(NUM_WRITE)).
  - With NUM_WRITE=1 the LVT is constant 0 and synthesises away.
- Reset asserted mid-operation: all state clears immediately; writes in that cycle are lost.
- No stalls and no handshake; every port is accepted every cycle.

Optional Feature:
- Macro: REGFILE_LVT_BYPASS_EN.
- Defined: write-first forwarding.
  - If any enabled, non-dropped write targets readAddress[r] in the current cycle, readData[r] returns that write's data (the conflict winner when several match), combinationally.
  - Zero-register forcing still takes precedence.
- Undefined: no forwarding; read-old-value semantics as above.

Decomposition:
- Package regfile_lvt_pkg holds:
  - function port_width(n) returning max(1, $clog2(n));
  - localparam defaults matching the parameters above.
- Sub-module regfile_lvt_bank: one write port, NUM_READ async read ports, DEPTH x WIDTH flops, async active-low reset. Instantiated NUM_WRITE times.
- The LVT, conflict resolution, bypass and output muxes stay in the top module.

Test Plan:
- Reset with resetN low, then release; read all 32 addresses on all ports -> every readData = 0, writeConflict = 0.
- Port 0 writes 0xDEADBEEF to r5 in cycle N; read r5 in cycle N -> 0x00000000; in cycle N+1 -> 0xDEADBEEF.
- Port 0 writes 0x11111111 and port 1 writes 0x22222222, both to r7, same cycle -> r7 reads 0x11111111 next cycle; writeConflict = 1 for exactly one cycle.
- Port 1 writes 0xAAAA0000 to r3, then port 0 writes 0x0000BBBB to r3 two cycles later -> reads return 0xAAAA0000, then 0x0000BBBB; LVT[3] goes 1 then 0.
- ZERO_REG=1: port 1 writes 0xFFFFFFFF to r0 -> r0 reads 0; writeConflict stays 0 even if port 0 also targets r0 in the same cycle.
- REGFILE_LVT_BYPASS_EN defined: port 1 writes 0x12345678 to r9 while read port 0 reads r9 in the same cycle -> readData[0] = 0x12345678 in that cycle.

Source files
------------

// File: rtl/regfile_lvt_pkg.sv
// Shared defaults and helpers for the live-value-table register file.
package regfile_lvt_pkg;

  localparam int NUM_WRITE_DEF = 2;
  localparam int NUM_READ_DEF  = 2;
  localparam int DEPTH_DEF     = 32;
  localparam int WIDTH_DEF     = 32;
  localparam int ZERO_REG_DEF  = 1;

  // LVT entry width: never narrower than one bit so the table stays declarable.
  function automatic int port_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_lvt_bank.sv
// One write port's storage: NUM_READ identical replicas, each with its own async read port.
module regfile_lvt_bank #(
  parameter  int NUM_READ = 2,
  parameter  int DEPTH    = 32,
  parameter  int WIDTH    = 32,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                               clk,
  input  logic                               resetN,
  input  logic                               we_i,
  input  logic [ADDR_W-1:0]                  waddr_i,
  input  logic [WIDTH-1:0]                   wdata_i,
  input  logic [NUM_READ-1:0][ADDR_W-1:0]    raddr_i,
  output logic [NUM_READ-1:0][WIDTH-1:0]     rdata_o
);

  // Every replica takes the same write so each read port gets a private copy.
  for (genvar r = 0; r < NUM_READ; r++) begin : g_rep
    logic [DEPTH-1:0][WIDTH-1:0] mem_q;

    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)   mem_q <= '0;
      else if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o[r] = mem_q[raddr_i[r]];
  end

endmodule

// File: rtl/regfile_lvt_multiport.sv
// Multi-port register file: per-write-port replicated banks selected by a live-value table.
// Optional macro REGFILE_LVT_BYPASS_EN enables write-first forwarding to the read ports.
module regfile_lvt_multiport
  import regfile_lvt_pkg::*;
#(
  parameter  int NUM_WRITE = NUM_WRITE_DEF,
  parameter  int NUM_READ  = NUM_READ_DEF,
  parameter  int DEPTH     = DEPTH_DEF,
  parameter  int WIDTH     = WIDTH_DEF,
  parameter  int ZERO_REG  = ZERO_REG_DEF,
  localparam int ADDR_W    = $clog2(DEPTH),
  localparam int PORT_W    = port_width(NUM_WRITE)
) (
  input  logic                               clk,
  input  logic                               resetN,
  input  logic [NUM_WRITE-1:0]               writeEnable,
  input  logic [NUM_WRITE-1:0][ADDR_W-1:0]   writeAddress,
  input  logic [NUM_WRITE-1:0][WIDTH-1:0]    writeData,
  input  logic [NUM_READ-1:0][ADDR_W-1:0]    readAddress,
  output logic [NUM_READ-1:0][WIDTH-1:0]     readData,
  output logic                               writeConflict
);

  logic [NUM_WRITE-1:0]                          wr_req;
  logic [NUM_WRITE-1:0]                          wr_win;
  logic                                          conflict_d, conflict_q;
  logic [NUM_WRITE-1:0][NUM_READ-1:0][WIDTH-1:0] bank_rdata;
  logic [DEPTH-1:0][PORT_W-1:0]                  lvt_q;

  // Drop zero-register writes first so they never count toward a conflict,
  // then let the lowest-index surviving port own each contested address.
  always_comb begin
    wr_req     = '0;
    wr_win     = '0;
    conflict_d = 1'b0;
    for (int p = 0; p < NUM_WRITE; p++)
      wr_req[p] = writeEnable[p] && !(ZERO_REG != 0 && writeAddress[p] == '0);
    for (int p = 0; p < NUM_WRITE; p++) begin
      wr_win[p] = wr_req[p];
      for (int q = 0; q < p; q++)
        if (wr_req[q] && writeAddress[q] == writeAddress[p]) wr_win[p] = 1'b0;
      if (wr_req[p] && !wr_win[p]) conflict_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) conflict_q <= 1'b0;
    else         conflict_q <= conflict_d;
  end

  assign writeConflict = conflict_q;

  for (genvar p = 0; p < NUM_WRITE; p++) begin : g_bank
    regfile_lvt_bank #(
      .NUM_READ (NUM_READ),
      .DEPTH    (DEPTH),
      .WIDTH    (WIDTH)
    ) u_bank (
      .clk     (clk),
      .resetN  (resetN),
      .we_i    (wr_win[p]),
      .waddr_i (writeAddress[p]),
      .wdata_i (writeData[p]),
      .raddr_i (readAddress),
      .rdata_o (bank_rdata[p])
    );
  end

  // A single write port always holds the live copy; no table needed.
  if (NUM_WRITE == 1) begin : g_lvt_const
    assign lvt_q = '0;
  end else begin : g_lvt
    // Winners have distinct addresses, so loop order never matters here.
    always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
        lvt_q <= '0;
      end else begin
        for (int p = 0; p < NUM_WRITE; p++)
          if (wr_win[p]) lvt_q[writeAddress[p]] <= PORT_W'(p);
      end
    end
  end

  always_comb begin
    readData = '0;
    for (int r = 0; r < NUM_READ; r++) begin
      readData[r] = bank_rdata[lvt_q[readAddress[r]]][r];
`ifdef REGFILE_LVT_BYPASS_EN
      // At most one winner can match a given address.
      for (int p = 0; p < NUM_WRITE; p++)
        if (wr_win[p] && writeAddress[p] == readAddress[r]) readData[r] = writeData[p];
`endif
      if (ZERO_REG != 0 && readAddress[r] == '0) readData[r] = '0;
    end
  end

endmodule

// File: tb/tb_regfile_lvt_multiport.sv
// Scoreboard bench for regfile_lvt_multiport: driver queues expectations, monitor checks at mid-cycle.
module tb_regfile_lvt_multiport;

  localparam int NW = 2;
  localparam int NR = 2;
  localparam int AW = 5;
  localparam int W  = 32;
`ifdef REGFILE_LVT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                      clk = 1'b0;
  logic                      resetN;
  logic [NW-1:0]             writeEnable;
  logic [NW-1:0][AW-1:0]     writeAddress;
  logic [NW-1:0][W-1:0]      writeData;
  logic [NR-1:0][AW-1:0]     readAddress;
  logic [NR-1:0][W-1:0]      readData;
  logic                      writeConflict;

  regfile_lvt_multiport dut (
    .clk           (clk),
    .resetN        (resetN),
    .writeEnable   (writeEnable),
    .writeAddress  (writeAddress),
    .writeData     (writeData),
    .readAddress   (readAddress),
    .readData      (readData),
    .writeConflict (writeConflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;   // 0/1 = readData port, 2 = writeConflict
    logic [31:0] val;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  exp_t        m_e;
  logic [31:0] m_act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m_e = sb.pop_front();
      if (m_e.kind == 2) m_act = {31'b0, writeConflict};
      else               m_act = readData[m_e.kind];
      checks++;
      if (m_e.cyc != cyc || m_act !== m_e.val) begin
        errors++;
        $display("FAIL %s k%0d: got %h expected %h (cycle %0d, due %0d)",
                 m_e.nm, m_e.kind, m_act, m_e.val, cyc, m_e.cyc);
      end
    end
  end

  task automatic push(input int kind, input logic [31:0] val, input string nm);
    exp_t e;
    e.cyc = cyc; e.kind = kind; e.val = val; e.nm = nm;
    sb.push_back(e);
  endtask

  // Drive one cycle of inputs and queue what must be observed during that cycle.
  task automatic step(input logic [1:0] we,
                      input logic [4:0] wa0, input logic [31:0] wd0,
                      input logic [4:0] wa1, input logic [31:0] wd1,
                      input logic [4:0] ra0, input logic [31:0] e0,
                      input logic [4:0] ra1, input logic [31:0] e1,
                      input logic ec, input string nm);
    writeEnable     = we;
    writeAddress[0] = wa0; writeData[0] = wd0;
    writeAddress[1] = wa1; writeData[1] = wd1;
    readAddress[0]  = ra0; readAddress[1] = ra1;
    push(0, e0, nm);
    push(1, e1, nm);
    push(2, {31'b0, ec}, {nm, "_conflict"});
    @(posedge clk); #1;
  endtask

  initial begin
    resetN       = 1'b0;
    writeEnable  = '0;
    writeAddress = '0;
    writeData    = '0;
    readAddress  = '0;
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;

    for (int a = 0; a < 32; a++)
      step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'(a), 32'h0, 5'(31 - a), 32'h0, 1'b0, "reset_clear");

    // read-during-write returns old value
    step(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd5, BYP ? 32'hDEADBEEF : 32'h0,
         5'd5, BYP ? 32'hDEADBEEF : 32'h0, 1'b0, "rdw_r5");
    step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 32'hDEADBEEF, 5'd5, 32'hDEADBEEF, 1'b0, "after_r5");

    // same-address conflict, port 0 wins
    step(2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222, 5'd7, BYP ? 32'h11111111 : 32'h0,
         5'd7, BYP ? 32'h11111111 : 32'h0, 1'b0, "conflict_wr");
    step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 32'h11111111, 5'd7, 32'h11111111, 1'b1, "conflict_rd1");
    step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 32'h11111111, 5'd5, 32'hDEADBEEF, 1'b0, "conflict_rd2");

    // LVT moves from port 1 to port 0
    step(2'b10, 5'd0, 32'h0, 5'd3, 32'hAAAA0000, 5'd3, BYP ? 32'hAAAA0000 : 32'h0,
         5'd3, BYP ? 32'hAAAA0000 : 32'h0, 1'b0, "lvt_p1_wr");
    step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 32'hAAAA0000, 5'd3, 32'hAAAA0000, 1'b0, "lvt_p1_rd");
    step(2'b01, 5'd3, 32'h0000BBBB, 5'd0, 32'h0, 5'd3, BYP ? 32'h0000BBBB : 32'hAAAA0000,
         5'd3, BYP ? 32'h0000BBBB : 32'hAAAA0000, 1'b0, "lvt_p0_wr");
    step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 32'h0000BBBB, 5'd3, 32'h0000BBBB, 1'b0, "lvt_p0_rd");

    // zero register: writes dropped, no conflict
    step(2'b11, 5'd0, 32'h12121212, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, "zero_wr");
    step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, "zero_rd");

    // port 1 write with same-cycle read (forwarded only when bypass is built in)
    step(2'b10, 5'd0, 32'h0, 5'd9, 32'h12345678, 5'd9, BYP ? 32'h12345678 : 32'h0,
         5'd5, 32'hDEADBEEF, 1'b0, "bypass_r9");
    step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 32'h12345678, 5'd7, 32'h11111111, 1'b0, "after_r9");

    // independent addresses commit together
    step(2'b11, 5'd10, 32'hCAFE0001, 5'd11, 32'hCAFE0002, 5'd10, BYP ? 32'hCAFE0001 : 32'h0,
         5'd11, BYP ? 32'hCAFE0002 : 32'h0, 1'b0, "dual_wr");
    step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd10, 32'hCAFE0001, 5'd11, 32'hCAFE0002, 1'b0, "dual_rd");

    // port 1 overrides a port 0 value
    step(2'b10, 5'd0, 32'h0, 5'd5, 32'h55555555, 5'd5, BYP ? 32'h55555555 : 32'hDEADBEEF,
         5'd3, 32'h0000BBBB, 1'b0, "override_wr");
    step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 32'h55555555, 5'd3, 32'h0000BBBB, 1'b0, "override_rd");

    // mid-operation reset discards state and in-flight writes
    #2;
    resetN          = 1'b0;
    writeEnable     = 2'b11;
    writeAddress[0] = 5'd20; writeData[0] = 32'h01010101;
    writeAddress[1] = 5'd20; writeData[1] = 32'h02020202;
    @(posedge clk); #1;
    resetN      = 1'b1;
    writeEnable = '0;
    step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd20, 32'h0, 5'd5, 32'h0, 1'b0, "midreset_a");
    step(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 32'h0, 5'd3, 32'h0, 1'b0, "midreset_b");

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      $display("FAIL drain: %0d expectations unchecked, required 0", sb.size());
      errors += sb.size();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
